// File: rtl/bcd_to_seg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_to_seg : registered 4-bit code to seven-segment decoder (0-9, A-F)   |
// | with lamp test and blanking. Define SEG_ACTIVE_LOW_EN for common-anode.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bcd_to_seg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] seg,
  output logic       is_hex
);

  logic [6:0] seg_q;
  logic [6:0] dec;
  logic       is_hex_q;

  // Segment order {a,b,c,d,e,f,g}; register holds active-high pattern.
  always_comb begin
    dec = 7'b0000000;
    case (bcd)
      4'h0: dec = 7'b1111110;
      4'h1: dec = 7'b0110000;
      4'h2: dec = 7'b1101101;
      4'h3: dec = 7'b1111001;
      4'h4: dec = 7'b0110011;
      4'h5: dec = 7'b1011011;
      4'h6: dec = 7'b1011111;
      4'h7: dec = 7'b1110000;
      4'h8: dec = 7'b1111111;
      4'h9: dec = 7'b1111011;
      4'hA: dec = 7'b1110111;
      4'hB: dec = 7'b0011111;
      4'hC: dec = 7'b1001110;
      4'hD: dec = 7'b0111101;
      4'hE: dec = 7'b1001111;
      4'hF: dec = 7'b1000111;
    endcase
  end

  // Lamp test overrides the load enable; blank only acts on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= 7'b0000000;
      is_hex_q <= 1'b0;
    end else if (lamp_test) begin
      seg_q    <= 7'b1111111;
      is_hex_q <= 1'b0;
    end else if (en) begin
      if (blank) begin
        seg_q    <= 7'b0000000;
        is_hex_q <= 1'b0;
      end else begin
        seg_q    <= dec;
        is_hex_q <= (bcd >= 4'hA);
      end
    end
  end

`ifdef SEG_ACTIVE_LOW_EN
  assign seg = ~seg_q;
`else
  assign seg = seg_q;
`endif

  assign is_hex = is_hex_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_seg.sv
`default_nettype none
// Testbench for bcd_to_seg: directed steps with a scoreboard queue of
// expected {seg,is_hex} values popped one clock after each drive.
module tb_bcd_to_seg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] bcd = 4'h0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [6:0] seg;
  logic       is_hex;

  int tests = 0;
  int fails = 0;

  logic [6:0] tbl [16];
  logic [6:0] m_seg = 7'b0000000;
  logic       m_hex = 1'b0;
  logic [7:0] sb_q [$];

  bcd_to_seg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bcd       (bcd),
    .blank     (blank),
    .lamp_test (lamp_test),
    .seg       (seg),
    .is_hex    (is_hex)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] disp(input logic [6:0] s);
`ifdef SEG_ACTIVE_LOW_EN
    return ~s;
`else
    return s;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = {seg, is_hex};
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed seg=%b is_hex=%b, expected seg=%b is_hex=%b",
             tag, got[7:1], got[0], exp[7:1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs, predict the registered result, compare after the edge.
  task automatic step(input string tag, input logic e, input logic [3:0] b,
                      input logic bl, input logic lt);
    logic [7:0] exp;
    @(negedge clk);
    en = e; bcd = b; blank = bl; lamp_test = lt;
    if (lt) begin
      m_seg = 7'b1111111; m_hex = 1'b0;
    end else if (e && bl) begin
      m_seg = 7'b0000000; m_hex = 1'b0;
    end else if (e) begin
      m_seg = tbl[b]; m_hex = (b > 4'd9);
    end
    sb_q.push_back({disp(m_seg), m_hex});
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check(tag, exp);
  endtask

  initial begin
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Reset held: outputs off even with load requested.
    en = 1'b1; bcd = 4'h8;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {disp(7'b0000000), 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

    for (int i = 0; i < 16; i++)
      step($sformatf("sweep_%h", i[3:0]), 1'b1, i[3:0], 1'b0, 1'b0);

    step("load_5",        1'b1, 4'h5, 1'b0, 1'b0);
    step("hold_en0",      1'b0, 4'h8, 1'b0, 1'b0);
    step("blank_en0",     1'b0, 4'h8, 1'b1, 1'b0);
    step("load_F",        1'b1, 4'hF, 1'b0, 1'b0);
    step("lamp_en0",      1'b0, 4'h3, 1'b0, 1'b1);
    step("lamp_release",  1'b0, 4'h3, 1'b0, 1'b0);
    step("load_7",        1'b1, 4'h7, 1'b0, 1'b0);
    step("lamp_over_blk", 1'b1, 4'h1, 1'b1, 1'b1);
    step("blank_2",       1'b1, 4'h2, 1'b1, 1'b0);
    step("unblank_2",     1'b1, 4'h2, 1'b0, 1'b0);
    step("load_C",        1'b1, 4'hC, 1'b0, 1'b0);
    step("load_9",        1'b1, 4'h9, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle, then inputs ignored while held.
    @(negedge clk);
    en = 1'b1; bcd = 4'hA;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {disp(7'b0000000), 1'b0});
    @(posedge clk);
    #1;
    check("reset_ignores_in", {disp(7'b0000000), 1'b0});
    m_seg = 7'b0000000; m_hex = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

    step("post_reset_hold", 1'b0, 4'h4, 1'b0, 1'b0);
    step("post_reset_E",    1'b1, 4'hE, 1'b0, 1'b0);
    step("post_reset_0",    1'b1, 4'h0, 1'b0, 1'b0);
    step("post_reset_1",    1'b1, 4'h1, 1'b0, 1'b0);

    tests++;
    assert (sb_q.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0d entries, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_to_seg.md
# bcd_to_seg

Registered 4-bit-code to seven-segment decoder for the frequency-counter display path. Each enabled cycle it captures a nibble from the digit counter/mux and drives the corresponding segment pattern (0–9 plus hex glyphs A–F) to one display digit. Lamp-test and blanking controls support display bring-up and leading-zero suppression upstream.

## Interface
- No parameters.
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  asynchronous reset, active-low.
- `en`  input  1  load enable; `bcd` is decoded and registered when high.
- `bcd`  input  4  code to display, 0x0–0xF.
- `blank`  input  1  forces all segments off on the next load.
- `lamp_test`  input  1  forces all segments on; independent of `en`.
- `seg`  output  7  segment drive, bit order {a,b,c,d,e,f,g} = seg[6:0], active-high by default.
- `is_hex`  output  1  registered flag, high when the displayed code is 0xA–0xF.

## Operation
- Decode table, code -> {a..g}:
  - 0 -> 1111110
  - 1 -> 0110000
  - 2 -> 1101101
  - 3 -> 1111001
  - 4 -> 0110011
  - 5 -> 1011011
  - 6 -> 1011111
  - 7 -> 1110000
  - 8 -> 1111111
  - 9 -> 1111011
  - A -> 1110111
  - b -> 0011111
  - C -> 1001110
  - d -> 0111101
  - E -> 1001111
  - F -> 1000111
- Decode is purely combinational. The result is held in a 7-bit output register plus the `is_hex` register.
- Priority, evaluated each clock edge:
  1. `lamp_test`=1: seg register <= 1111111, `is_hex` <= 0. Applies regardless of `en`.
  2. Else `en`=1 and `blank`=1: seg register <= 0000000, `is_hex` <= 0.
  3. Else `en`=1: seg register <= table(`bcd`), `is_hex` <= (`bcd` >= 4'hA).
  4. Else: hold.
- `blank` with `en`=0 has no effect; the display holds.
- After `lamp_test` deasserts with `en`=0, the output stays all-on until the next load.
- All 16 codes are defined. There is no X or don't-care decode.

## Timing
- Latency: 1 clock from `en`/`bcd` sampled at an edge to `seg` valid after that edge.
- Throughput: one new code per cycle.
- Reset (`rst_n`=0, asynchronous assertion): seg register = 0000000 (all segments off), `is_hex` = 0, immediately and independent of `clk`.
- Reset deassertion is synchronized externally. The first load occurs at the first edge with `rst_n`=1.
- Reset mid-operation: outputs clear immediately. Inputs are ignored until release.

## Configuration
- `SEG_ACTIVE_LOW_EN` defined: `seg` is the bitwise inverse of the register, for common-anode displays.
  - Reset value on `seg` becomes 1111111.
  - Lamp test drives 0000000; blank drives 1111111.
  - `is_hex` is unaffected.
- Undefined: `seg` is driven active-high exactly as in the table.

## Test plan
- Assert `rst_n`=0 mid-stream with `seg`=1111011 -> `seg`=0000000 and `is_hex`=0 before the next `clk` edge.
- Sweep `bcd` 0x0..0xF with `en`=1 -> each table value appears one cycle later (e.g., 0x3 -> 1111001, 0xD -> 0111101); `is_hex`=1 only for 0xA–0xF.
- Load 0x5, then drive `en`=0 and `bcd`=0x8 -> `seg` holds 1011011.
- Drive `lamp_test`=1 with `en`=0 -> 1111111 next cycle. Then `lamp_test`=0, `en`=1, `bcd`=0x7 -> 1110000.
- Drive `en`=1, `blank`=1, `bcd`=0x2 -> 0000000. Then deassert `blank` -> 1101101.
- With `SEG_ACTIVE_LOW_EN`: reset -> 1111111; `bcd`=0x0 -> 0000001; `bcd`=0x1 -> 1001111.
